multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle opcode decoder: a Moore FSM that sequences each MIPS32 instruction over 3–5 cycles.
- Drives the shared-ALU/shared-memory datapath: PC, IR, register file, ALU muxes, and a single unified memory port.
- Beyond the single-cycle decoder it adds a wider ALU-op field that distinguishes ORI/ANDI/SLTI, memory wait-state handshake with timeout, pipeline-freeze input, and sticky illegal-opcode/timeout traps.

Parameters:
- ALU_OP_W, 3, ALU operation field width; must be >=3; bits above [2] are driven 0.
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
- STALL_LIMIT, 15, max consecutive wait cycles in one memory state before trap; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- stall  in  1  freeze request
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = A register
- alu_src_b  out  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2
- alu_op  out  ALU_OP_W  000 ADD, 001 SUB, 010 FUNCT, 011 OR, 100 AND, 101 SLT
- state  out  4  current state, for debug
- illegal_op  out  1  sticky: unsupported opcode trapped
- mem_timeout  out  1  sticky: memory wait exceeded STALL_LIMIT

Behaviour:
- Reset (asynchronous, rst_n = 0): state = IDLE (0), timeout counter 0, illegal_op = 0, mem_timeout = 0. All outputs are 0 while in IDLE.
- The first rising edge with rst_n = 1 moves IDLE to FETCH.
- Outputs are Moore, decoded combinationally from state, except where noted as gated by mem_ready.
- Unlisted outputs are 0 in every state.

State encoding, outputs and transitions:
- FETCH (1): mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ADD. ir_write = pc_write = mem_ready. Goes to DECODE on mem_ready, otherwise stays.
- DECODE (2): alu_src_a = 0, alu_src_b = 11, alu_op = ADD. Next state by opcode:
  - 100011 (LW) or 101011 (SW) -> MEM_ADDR
  - 000000 -> R_EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 / 001101 / 001100 / 001010 -> I_EXEC
  - any other opcode -> TRAP, and sets illegal_op.
- MEM_ADDR (3): alu_src_a = 1, alu_src_b = 10, ADD. Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD (4): mem_read = 1, i_or_d = 1. Goes to MEM_WB on mem_ready.
- MEM_WB (5): reg_dst = 0, mem_to_reg = 1, reg_write = 1. Goes to FETCH.
- MEM_WR (6): mem_write = 1, i_or_d = 1. Goes to FETCH on mem_ready.
- R_EXEC (7): alu_src_a = 1, alu_src_b = 00, alu_op = FUNCT. Goes to R_WB.
- R_WB (8): reg_dst = 1, reg_write = 1. Goes to FETCH.
- BRANCH (9): alu_src_a = 1, alu_src_b = 00, SUB, pc_write_cond = 1, pc_source = 01. Goes to FETCH.
- JUMP (10): pc_write = 1, pc_source = 10. Goes to FETCH.
- I_EXEC (11): alu_src_a = 1, alu_src_b = 10. alu_op by opcode: ADDI -> ADD, ORI -> OR, ANDI -> AND, SLTI -> SLT. The opcode value is captured in DECODE and held in a register for this state. Goes to I_WB.
- I_WB (12): reg_dst = 0, reg_write = 1. Goes to FETCH.
- TRAP (13): all strobes 0. Stays in TRAP until reset.
- Encodings 14 and 15 are unreachable; if entered, the FSM goes to TRAP and sets illegal_op.

Instruction latency (mem_ready = 1 throughout):
- LW: 5 cycles. SW: 4. R-type: 4. I-type: 4. BEQ: 3. J: 3.
- Each cycle with mem_ready = 0 in FETCH, MEM_RD or MEM_WR adds one cycle.

Timeout:
- The counter increments on each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready = 0 and stall = 0.
- It clears on any state change.
- If the counter equals STALL_LIMIT and mem_ready = 0, the next state is TRAP and mem_timeout is set.
- mem_ready arriving in the same cycle the limit is reached wins: normal transition, no trap.

Stall:
- stall = 1 holds the state and timeout counter.
- It forces pc_write, pc_write_cond, ir_write, reg_write and mem_write to 0. mem_read, the muxes and alu_op are unchanged.
- stall has priority over mem_ready.
- stall has no effect in IDLE or TRAP.

Sticky flags and reset:
- illegal_op and mem_timeout are registered; once set they clear only on reset.
- Reset mid-instruction aborts immediately: state IDLE, all outputs 0 in the same cycle (asynchronous).

Test Plan:
- LW (100011), mem_ready = 1 -> state 1,2,3,4,5,1. reg_write = 1 and mem_to_reg = 1 only in cycle 5. ir_write = 1 only in cycle 1.
- ORI (001101) then ANDI (001100) then SLTI (001010) -> in I_EXEC, alu_op = 011, 100, 101 respectively, alu_src_b = 10. I_WB asserts reg_write with reg_dst = 0.
- SW with mem_ready low for 3 cycles in MEM_WR -> mem_write held 4 cycles, then FETCH. Total 7 cycles. mem_timeout stays 0.
- STALL_LIMIT = 4, mem_ready held 0 in FETCH -> TRAP after 5 FETCH cycles, mem_timeout = 1, held until rst_n pulse.
- Opcode 111111 -> DECODE then TRAP, illegal_op = 1. Pulse rst_n low in R_EXEC on a later run -> outputs 0 immediately, state 0, then FETCH.
- stall = 1 for 2 cycles during R_WB -> reg_write = 0 in those cycles, state remains 8, then reg_write = 1 for one cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS32 control FSM with memory wait/timeout, freeze and sticky traps
module multicycle_control #(
    parameter int ALU_OP_W      = 3,
    parameter int MEM_HANDSHAKE = 1,
    parameter int STALL_LIMIT   = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic                mem_ready,
    input  logic                stall,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [3:0]          state,
    output logic                illegal_op,
    output logic                mem_timeout
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_I_EXEC   = 4'd11,
        S_I_WB     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int CNT_W = $clog2(STALL_LIMIT + 2);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_opcode;
    logic             r_illegal;
    logic             r_timeout;

    state_t           w_next;
    logic             w_ready;
    logic             w_wait_state;
    logic             w_limit_hit;
    logic             w_bad_state;
    logic             w_pc_write;
    logic             w_pc_write_cond;
    logic             w_ir_write;
    logic             w_reg_write;
    logic             w_mem_write;
    logic [2:0]       w_alu_op;

    assign w_ready      = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_limit_hit  = (STALL_LIMIT != 0) && (r_cnt == CNT_W'(STALL_LIMIT));
    assign w_bad_state  = (r_state > S_TRAP);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = S_FETCH;
            S_FETCH:    w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                     w_next = S_MEM_ADDR;
                    OP_RTYPE:                         w_next = S_R_EXEC;
                    OP_BEQ:                           w_next = S_BRANCH;
                    OP_J:                             w_next = S_JUMP;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI: w_next = S_I_EXEC;
                    default:                          w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: w_next = (r_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = S_MEM_WB;
            S_MEM_WB:   w_next = S_FETCH;
            S_MEM_WR:   w_next = S_FETCH;
            S_R_EXEC:   w_next = S_R_WB;
            S_R_WB:     w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            S_I_EXEC:   w_next = S_I_WB;
            S_I_WB:     w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_TRAP;
        endcase
    end

    // Freeze holds everything; a memory state without ready either waits or times out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_opcode  <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_bad_state) begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
            r_cnt     <= '0;
        end else if (r_state == S_IDLE) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else if ((r_state != S_TRAP) && !stall) begin
            if (w_wait_state && !w_ready) begin
                if (w_limit_hit) begin
                    r_state   <= S_TRAP;
                    r_timeout <= 1'b1;
                    r_cnt     <= '0;
                end else if (STALL_LIMIT != 0) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_state <= w_next;
                r_cnt   <= '0;
                if (r_state == S_DECODE) begin
                    r_opcode <= opcode;
                    if (w_next == S_TRAP) begin
                        r_illegal <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_write     = 1'b0;
        w_alu_op        = 3'b000;
        pc_source       = 2'b00;
        i_or_d          = 1'b0;
        mem_read        = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                w_ir_write = w_ready;
                w_pc_write = w_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg  = 1'b1;
                w_reg_write = 1'b1;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                i_or_d      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                w_alu_op  = 3'b010;
            end
            S_R_WB: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                w_alu_op        = 3'b001;
                w_pc_write_cond = 1'b1;
                pc_source       = 2'b01;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                pc_source  = 2'b10;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (r_opcode)
                    OP_ORI:  w_alu_op = 3'b011;
                    OP_ANDI: w_alu_op = 3'b100;
                    OP_SLTI: w_alu_op = 3'b101;
                    default: w_alu_op = 3'b000;
                endcase
            end
            S_I_WB:     w_reg_write = 1'b1;
            default: begin
            end
        endcase
    end

    // Freeze suppresses only state-changing strobes; reads and mux selects stay live.
    assign pc_write      = w_pc_write & ~stall;
    assign pc_write_cond = w_pc_write_cond & ~stall;
    assign ir_write      = w_ir_write & ~stall;
    assign reg_write     = w_reg_write & ~stall;
    assign mem_write     = w_mem_write & ~stall;
    assign alu_op        = ALU_OP_W'(w_alu_op);
    assign state         = r_state;
    assign illegal_op    = r_illegal;
    assign mem_timeout   = r_timeout;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed and randomized checks of multicycle_control against an instruction-path model
module tb_multicycle_control;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       stall = 1'b0;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op, mem_timeout;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;

    multicycle_control #(
        .ALU_OP_W(3),
        .MEM_HANDSHAKE(1),
        .STALL_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .opcode(opcode),
        .mem_ready(mem_ready),
        .stall(stall),
        .pc_write(pc_write),
        .pc_write_cond(pc_write_cond),
        .pc_source(pc_source),
        .i_or_d(i_or_d),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .ir_write(ir_write),
        .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg),
        .reg_write(reg_write),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .alu_op(alu_op),
        .state(state),
        .illegal_op(illegal_op),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcs;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aop;
    } outs_t;

    outs_t got;
    assign got = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

    int   n_pass = 0;
    int   n_total = 0;
    int   m_st = 0;
    int   m_idx = 0;
    int   m_cnt = 0;
    logic m_ill = 1'b0;
    logic m_to = 1'b0;
    bit   m_done = 1'b0;
    int   m_path[$];
    int   lat;

    // Expected control word per state, written from the state descriptions.
    function automatic outs_t exp_outs(int st, logic [5:0] op, logic rdy, logic stl);
        outs_t o = '0;
        case (st)
            1:  begin o.mr = 1'b1; o.asb = 2'b01; o.irw = rdy; o.pcw = rdy; end
            2:  o.asb = 2'b11;
            3:  begin o.asa = 1'b1; o.asb = 2'b10; end
            4:  begin o.mr = 1'b1; o.iord = 1'b1; end
            5:  begin o.m2r = 1'b1; o.rw = 1'b1; end
            6:  begin o.mw = 1'b1; o.iord = 1'b1; end
            7:  begin o.asa = 1'b1; o.aop = 3'd2; end
            8:  begin o.rdst = 1'b1; o.rw = 1'b1; end
            9:  begin o.asa = 1'b1; o.aop = 3'd1; o.pcwc = 1'b1; o.pcs = 2'b01; end
            10: begin o.pcw = 1'b1; o.pcs = 2'b10; end
            11: begin
                o.asa = 1'b1;
                o.asb = 2'b10;
                case (op)
                    6'b001101: o.aop = 3'd3;
                    6'b001100: o.aop = 3'd4;
                    6'b001010: o.aop = 3'd5;
                    default:   o.aop = 3'd0;
                endcase
            end
            12: o.rw = 1'b1;
            default: begin
            end
        endcase
        if (stl) begin
            o.pcw = 1'b0; o.pcwc = 1'b0; o.irw = 1'b0; o.rw = 1'b0; o.mw = 1'b0;
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_now();
        chk("state", 32'(state), 32'(m_st));
        chk("outputs", 32'(got), 32'(exp_outs(m_st, opcode, mem_ready, stall)));
        chk("illegal_op", 32'(illegal_op), 32'(m_ill));
        chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
    endtask

    // Model: each instruction is a fixed path of states; waits and freezes only delay it.
    task automatic model_step(input logic rdy, input logic stl);
        m_done = 1'b0;
        if (m_st == 0) begin
            m_st = 1; m_idx = 0; m_cnt = 0;
        end else if (m_st == 13 || stl) begin
        end else if ((m_st == 1 || m_st == 4 || m_st == 6) && !rdy) begin
            if (m_cnt == LIMIT) begin
                m_st = 13; m_to = 1'b1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            m_cnt = 0;
            m_idx++;
            if (m_idx >= m_path.size()) begin
                m_st = 1; m_idx = 0; m_done = 1'b1;
            end else begin
                m_st = m_path[m_idx];
                if (m_st == 13) m_ill = 1'b1;
            end
        end
    endtask

    task automatic start_instr(input logic [5:0] op);
        opcode = op;
        case (op)
            6'b100011: m_path = '{1, 2, 3, 4, 5};
            6'b101011: m_path = '{1, 2, 3, 6};
            6'b000000: m_path = '{1, 2, 7, 8};
            6'b000100: m_path = '{1, 2, 9};
            6'b000010: m_path = '{1, 2, 10};
            6'b001000, 6'b001101, 6'b001100, 6'b001010: m_path = '{1, 2, 11, 12};
            default:   m_path = '{1, 2, 13};
        endcase
    endtask

    task automatic cycle(input logic rdy, input logic stl);
        mem_ready = rdy;
        stall = stl;
        #1;
        check_now();
        @(posedge clk);
        model_step(rdy, stl);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_st = 0; m_idx = 0; m_cnt = 0; m_ill = 1'b0; m_to = 1'b0;
        check_now();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0);
    endtask

    task automatic run_instr(input logic [5:0] op, input bit rnd, output int cycles);
        logic r, s;
        start_instr(op);
        cycles = 0;
        for (int k = 0; k < 64; k++) begin
            r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
            cycle(r, s);
            cycles++;
            if (m_done || m_st == 13) break;
        end
        if (!m_done && m_st != 13) chk("instr_bound", 32'(m_done), 32'd1);
    endtask

    logic [5:0] ops [11] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
                             6'b001000, 6'b001101, 6'b001100, 6'b001010, 6'b000000, 6'b010001};

    initial begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_now();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b1);

        run_instr(6'b100011, 1'b0, lat);
        chk("lw_latency", 32'(lat), 32'd5);
        run_instr(6'b001101, 1'b0, lat);
        chk("ori_latency", 32'(lat), 32'd4);
        run_instr(6'b001100, 1'b0, lat);
        run_instr(6'b001010, 1'b0, lat);
        run_instr(6'b000100, 1'b0, lat);
        chk("beq_latency", 32'(lat), 32'd3);
        run_instr(6'b000010, 1'b0, lat);
        chk("j_latency", 32'(lat), 32'd3);
        run_instr(6'b000000, 1'b0, lat);
        chk("r_latency", 32'(lat), 32'd4);

        start_instr(6'b101011);
        cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0);
        chk("sw_waiting_state", 32'(state), 32'd6);
        cycle(1'b1, 1'b0);
        chk("sw_done_state", 32'(state), 32'd1);

        start_instr(6'b000000);
        cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1); cycle(1'b1, 1'b1);
        chk("r_wb_after_stall", 32'(state), 32'd8);
        cycle(1'b1, 1'b0);

        start_instr(6'b100011);
        repeat (5) cycle(1'b0, 1'b0);
        chk("timeout_trap", 32'(mem_timeout), 32'd1);
        repeat (3) cycle(1'b1, 1'b1);
        do_reset();

        run_instr(6'b111111, 1'b0, lat);
        chk("illegal_trap", 32'(illegal_op), 32'd1);
        repeat (2) cycle(1'b1, 1'b0);
        do_reset();

        start_instr(6'b000000);
        cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
        chk("in_r_exec", 32'(state), 32'd7);
        do_reset();
        run_instr(6'b001000, 1'b0, lat);

        repeat (60) begin
            run_instr(ops[$urandom_range(0, 10)], 1'b1, lat);
            if (m_st == 13) begin
                cycle(1'b1, 1'b0);
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
